fetch_stage: RTL and testbench
==============================

# fetch_stage

Instruction-fetch stage of the five-stage RISC-V pipeline: owns the program counter, drives the instruction-memory request, and holds the IF/ID pipeline register. It sits directly upstream of the hazard unit and consumes its StallF, StallD and FlushD outputs. It also consumes the execute-stage redirect (PCSrcE with targets) that drives FlushD. Instruction-memory wait states are absorbed locally by holding the PC and injecting bubbles into Decode.

## Interface

- RESET_PC, 32'h0000_0000: PC value loaded by reset (word aligned).
- NOP_INSTR, 32'h0000_0013: encoding injected into InstrD on bubbles (addi x0,x0,0).

- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  reset; synchronous, active-high.
- StallF  in  1  hold PCF (load-use stall).
- StallD  in  1  hold IF/ID register.
- FlushD  in  1  replace IF/ID contents with a bubble.
- PCSrcE  in  2  redirect select: 00 sequential, 01 PCTargetE, 10 ALUResultE (jalr), 11 treated as 01.
- PCTargetE  in  32  branch/jal target.
- ALUResultE  in  32  jalr target (bit 0 cleared here).
- imem_req  out  1  fetch request; 0 during reset cycle, 1 otherwise.
- imem_addr  out  32  equals PCF.
- imem_rdata  in  32  instruction word for imem_addr, valid when imem_ready.
- imem_ready  in  1  imem_rdata valid this cycle.
- PCF  out  32  current fetch PC.
- InstrD  out  32  instruction for Decode.
- PCD  out  32  PC of InstrD.
- PCPlus4D  out  32  PCD + 4.
- ValidD  out  1  InstrD is a real fetched instruction (0 = bubble).
- FetchCount  out  32  instructions delivered to Decode since reset (wraps).
- BubbleCount  out  32  cycles Decode was loaded with a bubble from imem wait (wraps).

## Operation

- Redirect target: PCSrcE=01/11 → PCTargetE; 10 → {ALUResultE[31:1],1'b0}. Bit 1 of target passed through unchanged (misalignment is not checked here).
- PCF next-state priority: rst → RESET_PC; else PCSrcE≠00 → target (overrides StallF and imem_ready); else StallF or !imem_ready → hold; else PCF+4 (32-bit wrap: 32'hFFFF_FFFC → 0).
- IF/ID next-state priority: rst → InstrD=NOP_INSTR, PCD=0, PCPlus4D=0, ValidD=0; else FlushD → same bubble values; else StallD → hold all; else !imem_ready → bubble, BubbleCount+1; else load InstrD=imem_rdata, PCD=PCF, PCPlus4D=PCF+4, ValidD=1, FetchCount+1.
- Counters increment only on the load/bubble events above; FlushD and StallD cycles count nothing.
- StallF without StallD (not produced by the hazard unit) is legal: D reloads the same PCF word each cycle, FetchCount increments each cycle.
- A redirect with imem_ready=0 is not delayed; the not-ready response for the old PC is discarded because imem_addr changes on the next edge.

## Timing

- imem_addr/PCF combinational from PC register; memory read treated as same-cycle when imem_ready=1.
- Fetch latency: word at PCF in cycle N appears on InstrD in cycle N+1.
- Redirect: PCSrcE≠00 in cycle N → PCF=target in N+1 → target instruction on InstrD in N+2; InstrD in N+1 is a bubble (FlushD asserted in N by hazard unit).
- Load-use stall: StallF=StallD=1 in cycle N → PCF, InstrD, PCD, ValidD unchanged in N+1.
- Reset: asserted at edge N → all outputs at reset values in N+1 (PCF=RESET_PC, InstrD=NOP_INSTR, PCD=PCPlus4D=0, ValidD=0, counters 0, imem_req=0 while rst high). First real instruction on InstrD two cycles after rst deasserts (given imem_ready=1).
- Reset mid-stall or mid-redirect: rst wins over all inputs.

## Test plan

- Reset then imem_ready=1, memory word i = 0x1000+i: PCF 0,4,8,…; InstrD 0x1000,0x1001,… from cycle 2; ValidD=1; FetchCount=5 after 5 loads.
- StallF=StallD=1 for 2 cycles at PCF=0x8: PCF stays 0x8, InstrD/PCD hold word for 0x4, counters frozen; resumes 0xC next.
- PCSrcE=01, PCTargetE=0x40 with FlushD=1 and StallF=1 same cycle: PCF=0x40 next cycle, InstrD=NOP, ValidD=0; word at 0x40 on InstrD one cycle later.
- PCSrcE=10, ALUResultE=0x0000_0105: PCF becomes 0x104.
- imem_ready low 3 cycles at PCF=0x20: PCF holds 0x20, three bubbles, BubbleCount=3, then word 0x20 loaded with PCD=0x20.
- RESET_PC=32'hFFFF_FFF8, no stalls: PCF FFFF_FFF8, FFFF_FFFC, 0000_0000; rst asserted mid-run returns PCF to FFFF_FFF8 next cycle.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: program counter, instruction-memory request and the IF/ID register.
// Memory wait states hold the PC and send bubbles into Decode.
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        StallF,
    input  logic        StallD,
    input  logic        FlushD,
    input  logic [1:0]  PCSrcE,
    input  logic [31:0] PCTargetE,
    input  logic [31:0] ALUResultE,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ready,
    output logic [31:0] PCF,
    output logic [31:0] InstrD,
    output logic [31:0] PCD,
    output logic [31:0] PCPlus4D,
    output logic        ValidD,
    output logic [31:0] FetchCount,
    output logic [31:0] BubbleCount
);

    localparam int unsigned XLEN = 32;

    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] instr_q;
    logic [XLEN-1:0] pcd_q;
    logic [XLEN-1:0] pc_plus4d_q;
    logic            valid_q;
    logic [XLEN-1:0] fetch_cnt_q;
    logic [XLEN-1:0] bubble_cnt_q;
    logic [XLEN-1:0] target_c;
    logic [XLEN-1:0] pc_plus4_c;

    // jalr target has bit 0 cleared; encoding 11 behaves like 01
    always_comb begin
        target_c = PCTargetE;
        if (PCSrcE == 2'b10) begin
            target_c = ALUResultE & ~XLEN'(1);
        end
    end

    assign pc_plus4_c = pc_q + XLEN'(4);

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q         <= RESET_PC;
            instr_q      <= NOP_INSTR;
            pcd_q        <= '0;
            pc_plus4d_q  <= '0;
            valid_q      <= 1'b0;
            fetch_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            // a redirect overrides both the stall and a pending memory wait
            if (PCSrcE != 2'b00) begin
                pc_q <= target_c;
            end else if (!StallF && imem_ready) begin
                pc_q <= pc_plus4_c;
            end

            if (FlushD) begin
                instr_q     <= NOP_INSTR;
                pcd_q       <= '0;
                pc_plus4d_q <= '0;
                valid_q     <= 1'b0;
            end else if (!StallD) begin
                if (!imem_ready) begin
                    instr_q      <= NOP_INSTR;
                    pcd_q        <= '0;
                    pc_plus4d_q  <= '0;
                    valid_q      <= 1'b0;
                    bubble_cnt_q <= bubble_cnt_q + XLEN'(1);
                end else begin
                    instr_q     <= imem_rdata;
                    pcd_q       <= pc_q;
                    pc_plus4d_q <= pc_plus4_c;
                    valid_q     <= 1'b1;
                    fetch_cnt_q <= fetch_cnt_q + XLEN'(1);
                end
            end
        end
    end

    assign imem_req    = !rst;
    assign imem_addr   = pc_q;
    assign PCF         = pc_q;
    assign InstrD      = instr_q;
    assign PCD         = pcd_q;
    assign PCPlus4D    = pc_plus4d_q;
    assign ValidD      = valid_q;
    assign FetchCount  = fetch_cnt_q;
    assign BubbleCount = bubble_cnt_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Randomized and directed checks of fetch_stage against a cycle-level behavioural model.
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst, StallF, StallD, FlushD, imem_ready;
    logic [1:0]  PCSrcE;
    logic [31:0] PCTargetE, ALUResultE, imem_rdata;
    logic        imem_req, ValidD;
    logic [31:0] imem_addr, PCF, InstrD, PCD, PCPlus4D, FetchCount, BubbleCount;

    int checks = 0;
    int failures = 0;

    // reference state
    logic [31:0] m_pc, m_instr, m_pcd, m_p4, m_fc, m_bc;
    logic        m_valid;

    fetch_stage dut (
        .clk(clk), .rst(rst), .StallF(StallF), .StallD(StallD), .FlushD(FlushD),
        .PCSrcE(PCSrcE), .PCTargetE(PCTargetE), .ALUResultE(ALUResultE),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .imem_ready(imem_ready), .PCF(PCF), .InstrD(InstrD), .PCD(PCD),
        .PCPlus4D(PCPlus4D), .ValidD(ValidD), .FetchCount(FetchCount),
        .BubbleCount(BubbleCount)
    );

    always #5 clk = ~clk;

    // memory holds word i = 0x1000 + i
    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        return 32'h0000_1000 + (addr >> 2);
    endfunction

    assign imem_rdata = mem_word(imem_addr);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic bubble_model();
        m_instr = NOP; m_pcd = 0; m_p4 = 0; m_valid = 0;
    endtask

    // apply one cycle of inputs, advance the model, compare everything
    task automatic step(input logic r, input logic sf, input logic sd, input logic fd,
                        input logic [1:0] src, input logic [31:0] tgt,
                        input logic [31:0] alu, input logic rdy);
        logic [31:0] nxt;
        rst = r; StallF = sf; StallD = sd; FlushD = fd; PCSrcE = src;
        PCTargetE = tgt; ALUResultE = alu; imem_ready = rdy;
        #1;
        check("imem_req", 32'(imem_req), 32'(!r));
        @(posedge clk);
        if (r) begin
            m_pc = 0; bubble_model(); m_fc = 0; m_bc = 0;
        end else begin
            if (src == 2'b10)      nxt = alu - (alu % 2);
            else if (src != 2'b00) nxt = tgt;
            else if (sf || !rdy)   nxt = m_pc;
            else                   nxt = m_pc + 4;
            if (fd) bubble_model();
            else if (sd) ;
            else if (!rdy) begin bubble_model(); m_bc = m_bc + 1; end
            else begin
                m_instr = mem_word(m_pc); m_pcd = m_pc; m_p4 = m_pc + 4;
                m_valid = 1; m_fc = m_fc + 1;
            end
            m_pc = nxt;
        end
        #1;
        check("PCF", PCF, m_pc);
        check("imem_addr", imem_addr, m_pc);
        check("InstrD", InstrD, m_instr);
        check("PCD", PCD, m_pcd);
        check("PCPlus4D", PCPlus4D, m_p4);
        check("ValidD", 32'(ValidD), 32'(m_valid));
        check("FetchCount", FetchCount, m_fc);
        check("BubbleCount", BubbleCount, m_bc);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 2'b00, 0, 0, 1);
    endtask

    initial begin
        logic [31:0] bc0;
        m_pc = 0; bubble_model(); m_fc = 0; m_bc = 0;

        step(1, 0, 0, 0, 2'b00, 0, 0, 1);
        step(1, 1, 1, 1, 2'b01, 32'h40, 0, 0);
        check("rst_pc", PCF, 32'h0);
        check("rst_instr", InstrD, NOP);

        run(5);
        check("fc5", FetchCount, 32'd5);
        check("seq_instr", InstrD, 32'h0000_1004);
        check("seq_pc", PCF, 32'h14);

        step(0, 1, 1, 0, 2'b00, 0, 0, 1);
        step(0, 1, 1, 0, 2'b00, 0, 0, 1);
        check("stall_pc", PCF, 32'h14);
        check("stall_fc", FetchCount, 32'd5);
        run(1);
        check("resume_pc", PCF, 32'h18);

        step(0, 1, 0, 1, 2'b01, 32'h40, 0, 1);
        check("redir_pc", PCF, 32'h40);
        check("redir_bubble", 32'(ValidD), 32'h0);
        run(1);
        check("redir_instr", InstrD, 32'h0000_1010);
        check("redir_pcd", PCD, 32'h40);

        step(0, 0, 0, 1, 2'b10, 32'h80, 32'h0000_0105, 1);
        check("jalr_pc", PCF, 32'h104);
        step(0, 0, 0, 1, 2'b11, 32'h20, 0, 1);
        check("src11_pc", PCF, 32'h20);

        bc0 = BubbleCount;
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 2'b00, 0, 0, 0);
        check("wait_pc", PCF, 32'h20);
        check("wait_bc", BubbleCount, bc0 + 3);
        run(1);
        check("wait_pcd", PCD, 32'h20);

        step(0, 0, 0, 1, 2'b01, 32'hFFFF_FFF8, 0, 1);
        run(1);
        check("wrap_fffc", PCF, 32'hFFFF_FFFC);
        run(1);
        check("wrap_zero", PCF, 32'h0);
        check("wrap_p4d", PCPlus4D, 32'h0);
        step(1, 0, 0, 0, 2'b00, 0, 0, 1);
        check("midrst_pc", PCF, 32'h0);
        check("midrst_fc", FetchCount, 32'h0);

        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(63) == 0, $urandom_range(5) == 0, $urandom_range(5) == 0,
                 $urandom_range(7) == 0,
                 ($urandom_range(7) == 0) ? 2'($urandom_range(3)) : 2'b00,
                 $urandom, $urandom, $urandom_range(3) != 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
